// File: rtl/sbox_stream.sv
// sbox_stream: 4-direction CGRA switch box with per-input FIFOs, valid/ready channels
// and multicast routing; a word retires only once every subscribing output has taken it.
module sbox_stream #(
  parameter int W = 32,
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_we,
  input  logic [11:0]    cfg_data,
  input  logic [4*W-1:0] in_data,
  input  logic [3:0]     in_valid,
  output logic [3:0]     in_ready,
  output logic [4*W-1:0] out_data,
  output logic [3:0]     out_valid,
  input  logic [3:0]     out_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] SEL_OFF = 3'd4;
  logic [2:0]   sel [4];
  logic [W-1:0] mem [4][DEPTH];
  logic [AW-1:0] wp [4];
  logic [AW-1:0] rp [4];
  logic [AW:0]  cnt [4];
  logic [3:0]   taken, fire, push, pop, nempty, sub, done;
  always_comb begin
    nempty = '0;
    in_ready = '0;
    out_valid = '0;
    out_data = '0;
    sub = '0;
    done = '1;
    for (int i = 0; i < 4; i++) begin
      nempty[i] = cnt[i] != '0;
      in_ready[i] = cnt[i] != (AW+1)'(DEPTH);
    end
    for (int o = 0; o < 4; o++) begin
      out_valid[o] = !sel[o][2] && nempty[sel[o][1:0]] && !taken[o];
      out_data[W*o +: W] = out_valid[o] ? mem[sel[o][1:0]][rp[sel[o][1:0]]] : '0;
    end
    fire = out_valid & out_ready;
    // an input pops once every subscriber has either fired now or fired earlier
    for (int o = 0; o < 4; o++) begin
      sub[sel[o][1:0]] = sub[sel[o][1:0]] | !sel[o][2];
      done[sel[o][1:0]] = done[sel[o][1:0]] & (sel[o][2] | fire[o] | taken[o]);
    end
    pop = nempty & sub & done;
    push = in_valid & in_ready;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        sel[i] <= SEL_OFF;
        wp[i] <= '0;
        rp[i] <= '0;
        cnt[i] <= '0;
      end
      taken <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        wp[i] <= wp[i] + AW'(push[i]);
        rp[i] <= rp[i] + AW'(pop[i]);
        cnt[i] <= cnt[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
      end
      for (int o = 0; o < 4; o++) begin
        sel[o] <= cfg_we ? cfg_data[3*o +: 3] : sel[o];
        taken[o] <= !cfg_we && !(!sel[o][2] && pop[sel[o][1:0]]) && (taken[o] | fire[o]);
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (push[i]) mem[i][wp[i]] <= in_data[W*i +: W];
  end
endmodule

// File: tb/tb_sbox_stream.sv
// tb_sbox_stream: scenario tasks for sbox_stream; a negedge monitor pops per-output
// expected-word queues whenever an output fires.
module tb_sbox_stream;
  logic          clk = 0, reset = 0, cfg_we = 0;
  logic [11:0]   cfg_data = '0;
  logic [127:0]  in_data = '0;
  logic [3:0]    in_valid = '0, out_ready = '0;
  logic [3:0]    in_ready, out_valid;
  logic [127:0]  out_data;
  logic [31:0]   exp_q [4][$];
  logic [31:0]   mon_e;
  int errors = 0, checks = 0;

  sbox_stream #(.W(32), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_data(cfg_data),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset)
      for (int o = 0; o < 4; o++)
        if (out_valid[o] && out_ready[o]) begin
          checks++;
          if (exp_q[o].size() == 0) begin
            errors++;
            $display("FAIL fire_out%0d: got %h, expected no word", o, out_data[32*o +: 32]);
          end else begin
            mon_e = exp_q[o].pop_front();
            if (out_data[32*o +: 32] !== mon_e) begin
              errors++;
              $display("FAIL fire_out%0d: got %h expected %h", o, out_data[32*o +: 32], mon_e);
            end
          end
        end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [11:0] v);
    cfg_data = v;
    cfg_we = 1;
    tick();
    cfg_we = 0;
  endtask

  task automatic flush_q();
    for (int o = 0; o < 4; o++) exp_q[o].delete();
  endtask

  task automatic apply_reset();
    reset = 0;
    flush_q();
    #2 reset = 1;
    tick();
  endtask

  task automatic test_reset();
    reset = 0;
    #12 reset = 1;
    #1;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL rst_valid: got %b expected 0000", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_data: got %h expected 0", out_data); end
    checks++; if (in_ready !== 4'b1111) begin errors++; $display("FAIL rst_ready: got %b expected 1111", in_ready); end
    in_valid = 4'b0001;
    in_data[31:0] = 32'h0BAD_0000;
    tick();
    in_data[31:0] = 32'h0BAD_0001;
    tick();
    in_valid = 0;
    checks++; if (in_ready !== 4'b1110) begin errors++; $display("FAIL fill_ready: got %b expected 1110", in_ready); end
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL fill_valid: got %b expected 0000", out_valid); end
    apply_reset();
  endtask

  task automatic test_unicast();
    cfg(12'b100_100_100_010);
    out_ready = 4'b0001;
    in_valid = 4'b0100;
    in_data[95:64] = 32'hA5A5_0001;
    exp_q[0].push_back(32'hA5A5_0001);
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 4'b0001) begin errors++; $display("FAIL uni_valid: got %b expected 0001", out_valid); end
    checks++; if (out_data[31:0] !== 32'hA5A5_0001) begin errors++; $display("FAIL uni_data: got %h expected a5a50001", out_data[31:0]); end
    tick();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL uni_empty: got %b expected 0000", out_valid); end
    out_ready = 0;
  endtask

  task automatic test_multicast();
    cfg(12'b000_100_000_100);
    in_valid = 4'b0001;
    in_data[31:0] = 32'h0000_1111;
    for (int k = 0; k < 2; k++) begin
      exp_q[1].push_back(k == 0 ? 32'h1111 : 32'h2222);
      exp_q[3].push_back(k == 0 ? 32'h1111 : 32'h2222);
    end
    tick();
    in_data[31:0] = 32'h0000_2222;
    out_ready = 4'b0010;
    checks++; if (out_valid !== 4'b1010) begin errors++; $display("FAIL mc_t1_valid: got %b expected 1010", out_valid); end
    checks++; if (out_data[63:32] !== 32'h1111 || out_data[127:96] !== 32'h1111) begin errors++; $display("FAIL mc_t1_data: got %h/%h expected 1111", out_data[63:32], out_data[127:96]); end
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 4'b1000) begin errors++; $display("FAIL mc_t2_valid: got %b expected 1000", out_valid); end
    tick();
    checks++; if (out_valid !== 4'b1000) begin errors++; $display("FAIL mc_t3_valid: got %b expected 1000", out_valid); end
    out_ready = 4'b1010;
    tick();
    checks++; if (out_valid !== 4'b1010) begin errors++; $display("FAIL mc_t4_valid: got %b expected 1010", out_valid); end
    checks++; if (out_data[63:32] !== 32'h2222 || out_data[127:96] !== 32'h2222) begin errors++; $display("FAIL mc_t4_data: got %h/%h expected 2222", out_data[63:32], out_data[127:96]); end
    tick();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL mc_t5_valid: got %b expected 0000", out_valid); end
    out_ready = 0;
  endtask

  task automatic test_back_to_back();
    cfg(12'b100_011_100_100);
    in_valid = 4'b1000;
    in_data[127:96] = 32'hB000_0000;
    exp_q[2].push_back(32'hB000_0000);
    exp_q[2].push_back(32'hB000_0001);
    checks++; if (in_ready[3] !== 1'b1) begin errors++; $display("FAIL bp_ready0: got %b expected 1", in_ready[3]); end
    tick();
    in_data[127:96] = 32'hB000_0001;
    tick();
    in_data[127:96] = 32'hB000_0002;
    checks++; if (in_ready[3] !== 1'b0) begin errors++; $display("FAIL bp_full: got %b expected 0", in_ready[3]); end
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 4'b0100 || out_data[95:64] !== 32'hB000_0000) begin errors++; $display("FAIL bp_head: got %b/%h expected 0100/b0000000", out_valid, out_data[95:64]); end
    out_ready = 4'b0100;
    tick();
    checks++; if (in_ready[3] !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b expected 1", in_ready[3]); end
    checks++; if (out_data[95:64] !== 32'hB000_0001) begin errors++; $display("FAIL bp_second: got %h expected b0000001", out_data[95:64]); end
    tick();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL bp_drained: got %b expected 0000", out_valid); end
    out_ready = 0;
  endtask

  task automatic test_reconfig();
    cfg(12'b100_100_001_001);
    in_valid = 4'b1010;
    in_data[63:32] = 32'hC000_0001;
    in_data[127:96] = 32'hD000_0003;
    exp_q[0].push_back(32'hC000_0001);
    tick();
    in_valid = 0;
    out_ready = 4'b0001;
    checks++; if (out_valid !== 4'b0011) begin errors++; $display("FAIL rc_before: got %b expected 0011", out_valid); end
    tick();
    out_ready = 0;
    checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL rc_taken: got %b expected 0010", out_valid); end
    cfg(12'b100_100_001_011);
    checks++; if (out_valid !== 4'b0011) begin errors++; $display("FAIL rc_after: got %b expected 0011", out_valid); end
    checks++; if (out_data[31:0] !== 32'hD000_0003 || out_data[63:32] !== 32'hC000_0001) begin errors++; $display("FAIL rc_data: got %h/%h expected d0000003/c0000001", out_data[31:0], out_data[63:32]); end
    exp_q[0].push_back(32'hD000_0003);
    exp_q[1].push_back(32'hC000_0001);
    out_ready = 4'b0011;
    tick();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL rc_drained: got %b expected 0000", out_valid); end
    out_ready = 0;
  endtask

  task automatic test_reset_mid();
    cfg(12'b000_100_000_100);
    in_valid = 4'b0101;
    in_data[31:0] = 32'hE000_0000;
    in_data[95:64] = 32'hF000_0002;
    exp_q[1].push_back(32'hE000_0000);
    exp_q[3].push_back(32'hE000_0000);
    tick();
    in_valid = 0;
    out_ready = 4'b0010;
    tick();
    checks++; if (out_valid !== 4'b1000) begin errors++; $display("FAIL mid_partial: got %b expected 1000", out_valid); end
    #2 reset = 0;
    flush_q();
    #1;
    checks++; if (out_valid !== 4'b0000 || out_data !== '0) begin errors++; $display("FAIL mid_async: got %b/%h expected 0000/0", out_valid, out_data); end
    out_ready = 0;
    #2 reset = 1;
    tick();
    checks++; if (out_valid !== 4'b0000 || out_data !== '0) begin errors++; $display("FAIL mid_post_out: got %b/%h expected 0000/0", out_valid, out_data); end
    checks++; if (in_ready !== 4'b1111) begin errors++; $display("FAIL mid_post_ready: got %b expected 1111", in_ready); end
    in_valid = 4'b0001;
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL mid_sel_off: got %b expected 0000", out_valid); end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_multicast();
    test_back_to_back();
    test_reconfig();
    test_reset_mid();
    for (int o = 0; o < 4; o++) begin
      checks++;
      if (exp_q[o].size() != 0) begin errors++; $display("FAIL undelivered_out%0d: got %0d left expected 0", o, exp_q[o].size()); end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
